// File: rtl/reset_sequencer.sv
// Staged reset release: preset-flop synchronizer, stretch delay, then one RST_OUT bit per gap.
// Optional synchronous software reset is enabled by defining RESET_SEQUENCER_SW_RST_EN.
module reset_sequencer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STRETCH     = 16,
  parameter int unsigned GAP         = 4,
  parameter int unsigned NUM_OUT     = 3
) (
  input  logic               C,
  input  logic               PRE,
  input  logic               CE,
  input  logic               SW_RST,
  output logic [NUM_OUT-1:0] RST_OUT,
  output logic               READY,
  output logic [1:0]         STATE
);

  typedef enum logic [1:0] {
    StHold    = 2'd0,
    StStretch = 2'd1,
    StRelease = 2'd2,
    StRun     = 2'd3
  } state_e;

  localparam logic [7:0] StretchLast = 8'(STRETCH - 1);
  localparam logic [7:0] GapLast     = 8'(GAP - 1);
  localparam logic [1:0] LastIdx     = 2'(NUM_OUT - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_rst;
  state_e                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [1:0]             idx_q, idx_d, next_idx;
  logic [NUM_OUT-1:0]     rst_out_q, rst_out_d;
  logic                   ready_q, ready_d;
  logic                   sw_req;

`ifdef RESET_SEQUENCER_SW_RST_EN
  assign sw_req = SW_RST;
`else
  logic unused_sw_rst;
  assign unused_sw_rst = SW_RST;
  assign sw_req        = 1'b0;
`endif

  // Chain shifts zeros in every edge; only PRE can refill it with ones.
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], 1'b0};
  assign sync_rst = sync_q[SYNC_STAGES-1];
  assign next_idx = idx_q + 2'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    ready_d   = ready_q;

    if (sync_rst) begin
      state_d   = StHold;
      cnt_d     = 8'd0;
      idx_d     = 2'd0;
      rst_out_d = '1;
      ready_d   = 1'b0;
    end else if (sw_req && (state_q != StHold)) begin
      state_d   = StStretch;
      cnt_d     = 8'd0;
      idx_d     = 2'd0;
      rst_out_d = '1;
      ready_d   = 1'b0;
    end else begin
      unique case (state_q)
        StHold: begin
          state_d = StStretch;
          cnt_d   = 8'd0;
        end
        StStretch: begin
          if (CE) begin
            if (cnt_q == StretchLast) begin
              rst_out_d[0] = 1'b0;
              cnt_d        = 8'd0;
              if (NUM_OUT == 1) begin
                state_d = StRun;
                ready_d = 1'b1;
              end else begin
                state_d = StRelease;
              end
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        StRelease: begin
          if (CE) begin
            if (cnt_q == GapLast) begin
              for (int unsigned i = 0; i < NUM_OUT; i++) begin
                if (2'(i) == next_idx) rst_out_d[i] = 1'b0;
              end
              cnt_d = 8'd0;
              idx_d = next_idx;
              if (next_idx == LastIdx) begin
                state_d = StRun;
                ready_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        StRun: begin
          rst_out_d = '0;
          ready_d   = 1'b1;
        end
        default: state_d = StHold;
      endcase
    end
  end

  always_ff @(posedge C or posedge PRE) begin
    if (PRE) begin
      sync_q    <= '1;
      state_q   <= StHold;
      cnt_q     <= 8'd0;
      idx_q     <= 2'd0;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
    end
  end

  assign RST_OUT = rst_out_q;
  assign READY   = ready_q;
  assign STATE   = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected output events are queued per edge number
// when a sequence is started and consumed as the DUT reaches each edge.
module tb_reset_sequencer;

  typedef struct {
    int         edge_no;
    logic [3:0] rst;
    logic       ready;
    logic [1:0] state;
  } exp_t;

  logic       C = 1'b0;
  logic       PRE, pre1, CE, SW_RST;
  logic [2:0] rst0;
  logic       rdy0;
  logic [1:0] st0;
  logic [0:0] rst1;
  logic       rdy1;
  logic [1:0] st1;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   edge_n  = 0;
  int   ce_mode = 0;
  int   sw_edge = -1;
  int   sel     = 0;
  exp_t sb[$];
  exp_t cur;

  always #5 C = ~C;

  reset_sequencer dut (
    .C      (C),
    .PRE    (PRE),
    .CE     (CE),
    .SW_RST (SW_RST),
    .RST_OUT(rst0),
    .READY  (rdy0),
    .STATE  (st0)
  );

  reset_sequencer #(
    .SYNC_STAGES(2),
    .STRETCH    (1),
    .GAP        (1),
    .NUM_OUT    (1)
  ) dut_min (
    .C      (C),
    .PRE    (pre1),
    .CE     (CE),
    .SW_RST (SW_RST),
    .RST_OUT(rst1),
    .READY  (rdy1),
    .STATE  (st1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit ce_at(input int n);
    return (ce_mode == 0) || (n % 2 == 0);
  endfunction

  function automatic int advance(input int start, input int cnt);
    int n = start;
    int left = cnt;
    while (left > 0) begin
      n++;
      if (ce_at(n)) left--;
    end
    return n;
  endfunction

  task automatic push_seq(input int start, input int stretch, input int gap, input int nout);
    logic [3:0] r;
    int n;
    r = 4'((1 << nout) - 1);
    sb.push_back('{start, r, 1'b0, 2'd1});
    n = advance(start, stretch);
    r[0] = 1'b0;
    if (nout == 1) sb.push_back('{n, r, 1'b1, 2'd3});
    else           sb.push_back('{n, r, 1'b0, 2'd2});
    for (int k = 1; k < nout; k++) begin
      n = advance(n, gap);
      r[k] = 1'b0;
      if (k == nout - 1) sb.push_back('{n, r, 1'b1, 2'd3});
      else               sb.push_back('{n, r, 1'b0, 2'd2});
    end
  endtask

  task automatic reset_exp();
    int nout = (sel == 0) ? 3 : 1;
    cur = '{0, 4'((1 << nout) - 1), 1'b0, 2'd0};
  endtask

  task automatic compare_cur(input string tag);
    logic [3:0] r;
    logic       rd;
    logic [1:0] s;
    if (sel == 0) begin
      r = {1'b0, rst0}; rd = rdy0; s = st0;
    end else begin
      r = {3'b000, rst1}; rd = rdy1; s = st1;
    end
    check_eq($sformatf("%s.rst_out", tag), 32'(r), 32'(cur.rst));
    check_eq($sformatf("%s.ready", tag), 32'(rd), 32'(cur.ready));
    check_eq($sformatf("%s.state", tag), 32'(s), 32'(cur.state));
  endtask

  task automatic run_edges(input int num);
    for (int i = 0; i < num; i++) begin
      CE     = ce_at(edge_n + 1);
      SW_RST = (edge_n + 1 == sw_edge);
      @(posedge C);
      edge_n++;
      #1;
      if (sb.size() > 0 && sb[0].edge_no == edge_n) cur = sb.pop_front();
      compare_cur($sformatf("edge%0d", edge_n));
    end
    SW_RST = 1'b0;
  endtask

  task automatic drain_check(input string tag);
    check_eq($sformatf("%s.sb_drain", tag), 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic apply_pre(input int cycles);
    if (sel == 0) PRE = 1'b1; else pre1 = 1'b1;
    #1;
    reset_exp();
    compare_cur("pre_imm");
    repeat (cycles) @(posedge C);
    @(negedge C);
    if (sel == 0) PRE = 1'b0; else pre1 = 1'b0;
    SW_RST = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    PRE = 1'b1; pre1 = 1'b1; CE = 1'b1; SW_RST = 1'b0;
    cur = '{0, 4'b0111, 1'b0, 2'd0};

    // Nominal release timing with CE always high.
    apply_pre(5);
    push_seq(3, 16, 4, 3);
    run_edges(30);
    drain_check("nominal");

    // CE only on even edges stretches every interval; HOLD exit ignores CE.
    ce_mode = 1;
    apply_pre(5);
    push_seq(3, 16, 4, 3);
    run_edges(60);
    drain_check("ce_alt");
    ce_mode = 0;

    // Short asynchronous PRE pulse in RELEASE, then a full restart.
    apply_pre(5);
    push_seq(3, 16, 4, 3);
    run_edges(20);
    check_eq("mid_release.rst_out", 32'(rst0), 32'h6);
    sb.delete();
    #2 PRE = 1'b1;
    #1;
    reset_exp();
    compare_cur("pulse_imm");
    #2 PRE = 1'b0;
    edge_n = 0;
    push_seq(3, 16, 4, 3);
    run_edges(30);
    drain_check("restart");

    // One-cycle software reset while running.
    edge_n  = 0;
    sw_edge = 1;
`ifdef RESET_SEQUENCER_SW_RST_EN
    push_seq(1, 16, 4, 3);
`endif
    run_edges(30);
    sw_edge = -1;
    drain_check("sw_rst");

    // PRE and SW_RST together: PRE dominates.
    SW_RST = 1'b1;
    apply_pre(5);
    push_seq(3, 16, 4, 3);
    run_edges(30);
    drain_check("pre_and_sw");

    // Minimal configuration: single output, unit stretch and gap.
    sel = 1;
    apply_pre(5);
    push_seq(3, 1, 1, 1);
    run_edges(8);
    drain_check("minimal");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
